// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the UART-driven adder command controller.
package adder_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RX_OPD  = 3'd1,
      S_EXEC    = 3'd2,
      S_WAIT    = 3'd3,
      S_TX_LOAD = 3'd4,
      S_TX_WAIT = 3'd5
   } state_e;

   localparam logic [7:0] OPC_ADD = 8'h01;
   localparam logic [7:0] OPC_SUB = 8'h02;

   // status byte layout: {hdr[3:0], 0, dp_timeout, bad_opcode, ovf}
   localparam int ST_OVF_BIT  = 0;
   localparam int ST_BAD_BIT  = 1;
   localparam int ST_DPTO_BIT = 2;
   localparam logic [3:0] ST_HDR = 4'hA;

   function automatic logic [7:0] status_byte(input logic dpto, input logic bad,
                                              input logic ovf);
      logic [7:0] s;
      s = {ST_HDR, 4'h0};
      s[ST_DPTO_BIT] = dpto;
      s[ST_BAD_BIT]  = bad;
      s[ST_OVF_BIT]  = ovf;
      return s;
   endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle cycles between received bytes; flags when the gap reaches TIMEOUT_CYC.
module byte_gap_timer #(
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic CLK,
   input  logic RST,
   input  logic enable,
   input  logic clear,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // counter is held at zero outside the enabled window and on every accepted byte
   always_comb begin
      cnt_d = cnt_q;
      if (clear || !enable)
         cnt_d = '0;
      else if (cnt_q != CW'(TIMEOUT_CYC))
         cnt_d = cnt_q + 1'b1;
   end

   // idle-cycle counter register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   // the TIMEOUT_CYC-th idle cycle is the expiry cycle
   assign expired = enable && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/adder_cmd_ctrl.sv
// Frame parser, datapath sequencer and response transmitter for the adder command link.
module adder_cmd_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1000,
   parameter int DP_WAIT_MAX = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  Rx_Byte_in,
   input  logic        Rx_DV_in,
   input  logic        Tx_Done_in,
   output logic        Tx_DV_out,
   output logic [7:0]  Tx_Byte_out,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic        op_sub,
   output logic        op_start,
   input  logic [15:0] res,
   input  logic        res_ovf,
   input  logic        res_valid,
   output logic        err_pulse,
   output logic [7:0]  drop_cnt
);
   localparam int WW = $clog2(DP_WAIT_MAX + 1);

   state_e        state_q, state_d;
   logic [7:0]    opc_q, opc_d;
   logic [1:0]    idx_q, idx_d;
   logic [1:0]    tx_idx_q, tx_idx_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [15:0]   op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
   logic          op_sub_q, op_sub_d, op_start_q, op_start_d;
   logic          ovf_q, ovf_d, dpto_q, dpto_d;
   logic          tx_dv_q, tx_dv_d, err_q, err_d;
   logic [7:0]    tx_byte_q, tx_byte_d, drop_q, drop_d;
   logic          gap_expired, bad_opc;

   byte_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
      .CLK     (CLK),
      .RST     (RST),
      .enable  (state_q == S_RX_OPD),
      .clear   (Rx_DV_in),
      .expired (gap_expired)
   );

   assign bad_opc = (opc_q != OPC_ADD) && (opc_q != OPC_SUB);

   // next-state and datapath/TX control
   always_comb begin
      state_d    = state_q;
      opc_d      = opc_q;
      idx_d      = idx_q;
      tx_idx_d   = tx_idx_q;
      wait_d     = wait_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_sub_d   = op_sub_q;
      op_start_d = 1'b0;
      res_d      = res_q;
      ovf_d      = ovf_q;
      dpto_d     = dpto_q;
      tx_dv_d    = 1'b0;
      tx_byte_d  = tx_byte_q;
      err_d      = 1'b0;
      drop_d     = drop_q;
      case (state_q)
         S_IDLE: begin
            if (Rx_DV_in) begin
               opc_d    = Rx_Byte_in;
               idx_d    = 2'd0;
               tx_idx_d = 2'd0;
               dpto_d   = 1'b0;
               state_d  = S_RX_OPD;
            end
         end
         S_RX_OPD: begin
            // a byte arriving on the expiry cycle takes priority over the timeout
            if (Rx_DV_in) begin
               case (idx_q)
                  2'd0: op_a_d[15:8] = Rx_Byte_in;
                  2'd1: op_a_d[7:0]  = Rx_Byte_in;
                  2'd2: op_b_d[15:8] = Rx_Byte_in;
                  default: op_b_d[7:0] = Rx_Byte_in;
               endcase
               if (idx_q == 2'd3) begin
                  if (bad_opc) begin
                     res_d   = 16'h0000;
                     ovf_d   = 1'b0;
                     state_d = S_TX_LOAD;
                  end else begin
                     op_sub_d = (opc_q == OPC_SUB);
                     state_d  = S_EXEC;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (gap_expired) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            op_start_d = 1'b1;
            wait_d     = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (res_valid) begin
               res_d   = res;
               ovf_d   = res_ovf;
               state_d = S_TX_LOAD;
            end else if (wait_q == WW'(DP_WAIT_MAX - 1)) begin
               res_d   = 16'h0000;
               ovf_d   = 1'b0;
               dpto_d  = 1'b1;
               state_d = S_TX_LOAD;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_TX_LOAD: begin
            tx_dv_d = 1'b1;
            case (tx_idx_q)
               2'd0:    tx_byte_d = status_byte(dpto_q, bad_opc, ovf_q);
               2'd1:    tx_byte_d = res_q[15:8];
               default: tx_byte_d = res_q[7:0];
            endcase
            state_d = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (Tx_Done_in) begin
               if (tx_idx_q == 2'd2) begin
                  state_d = S_IDLE;
               end else begin
                  tx_idx_d = tx_idx_q + 1'b1;
                  state_d  = S_TX_LOAD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // bytes arriving while a command is in flight are dropped and counted
      if (Rx_DV_in && (state_q inside {S_EXEC, S_WAIT, S_TX_LOAD, S_TX_WAIT}) &&
          (drop_q != 8'hFF))
         drop_d = drop_q + 1'b1;
   end

   // state and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         opc_q      <= '0;
         idx_q      <= '0;
         tx_idx_q   <= '0;
         wait_q     <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_sub_q   <= 1'b0;
         op_start_q <= 1'b0;
         res_q      <= '0;
         ovf_q      <= 1'b0;
         dpto_q     <= 1'b0;
         tx_dv_q    <= 1'b0;
         tx_byte_q  <= '0;
         err_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         opc_q      <= opc_d;
         idx_q      <= idx_d;
         tx_idx_q   <= tx_idx_d;
         wait_q     <= wait_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_sub_q   <= op_sub_d;
         op_start_q <= op_start_d;
         res_q      <= res_d;
         ovf_q      <= ovf_d;
         dpto_q     <= dpto_d;
         tx_dv_q    <= tx_dv_d;
         tx_byte_q  <= tx_byte_d;
         err_q      <= err_d;
         drop_q     <= drop_d;
      end
   end

   assign Tx_DV_out   = tx_dv_q;
   assign Tx_Byte_out = tx_byte_q;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign op_sub      = op_sub_q;
   assign op_start    = op_start_q;
   assign err_pulse   = err_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_adder_cmd_ctrl.sv
// Directed bench for adder_cmd_ctrl with a 2-cycle adder model and a UART TX responder.
module tb_adder_cmd_ctrl;
   localparam int T = 1000;

   logic        CLK, RST;
   logic [7:0]  Rx_Byte_in;
   logic        Rx_DV_in, Tx_Done_in;
   logic        Tx_DV_out;
   logic [7:0]  Tx_Byte_out;
   logic [15:0] op_a, op_b, res;
   logic        op_sub, op_start, res_ovf, res_valid, err_pulse;
   logic [7:0]  drop_cnt;

   int total = 0, bad = 0;
   int n_start = 0, n_err = 0;
   int tx_delay = 1;
   bit dp_en = 1;
   logic [7:0]  tx_q[$];
   logic [15:0] cap_a, cap_b;
   logic        cap_sub;

   adder_cmd_ctrl #(.TIMEOUT_CYC(T), .DP_WAIT_MAX(16)) dut (
      .CLK(CLK), .RST(RST), .Rx_Byte_in(Rx_Byte_in), .Rx_DV_in(Rx_DV_in),
      .Tx_Done_in(Tx_Done_in), .Tx_DV_out(Tx_DV_out), .Tx_Byte_out(Tx_Byte_out),
      .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_start(op_start),
      .res(res), .res_ovf(res_ovf), .res_valid(res_valid),
      .err_pulse(err_pulse), .drop_cnt(drop_cnt)
   );

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   // adder datapath model, two stages between op_start and res_valid
   logic        v1, v2;
   logic [15:0] r1, r2;
   logic        o1, o2;
   initial begin
      v1 = 0; v2 = 0; r1 = 0; r2 = 0; o1 = 0; o2 = 0;
      res = 0; res_ovf = 0; res_valid = 0;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            v1 = 0; v2 = 0; res_valid = 0;
         end else begin
            res_valid = v2; res = r2; res_ovf = o2;
            v2 = v1; r2 = r1; o2 = o1;
            v1 = op_start && dp_en;
            r1 = op_sub ? op_a - op_b : op_a + op_b;
            o1 = op_sub ? (op_a[15] != op_b[15]) && (r1[15] != op_a[15])
                        : (op_a[15] == op_b[15]) && (r1[15] != op_a[15]);
         end
      end
   end

   // monitor: op_start, TX bytes, error pulses
   initial begin
      forever begin
         @(negedge CLK);
         if (RST) begin
            if (op_start) begin
               n_start++; cap_a = op_a; cap_b = op_b; cap_sub = op_sub;
            end
            if (Tx_DV_out) tx_q.push_back(Tx_Byte_out);
            if (err_pulse) n_err++;
         end
      end
   end

   // UART TX responder: Tx_Done_in tx_delay cycles after each Tx_DV_out
   initial begin
      Tx_Done_in = 0;
      forever begin
         @(negedge CLK);
         if (Tx_DV_out) begin
            repeat (tx_delay) @(negedge CLK);
            Tx_Done_in = 1;
            @(negedge CLK);
            Tx_Done_in = 0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      Rx_Byte_in = b; Rx_DV_in = 1;
      @(posedge CLK); #1;
      Rx_DV_in = 0;
   endtask

   task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
      send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
   endtask

   task automatic start_frame();
      tx_q.delete(); n_start = 0; n_err = 0;
   endtask

   // bounded wait for n TX bytes, then let the final Tx_Done settle
   task automatic wait_tx(input int n);
      int k;
      k = 0;
      while (tx_q.size() < n && k < 400) begin
         @(negedge CLK); k++;
      end
      repeat (tx_delay + 6) @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 0; Rx_DV_in = 0; Rx_Byte_in = 0;
      repeat (3) @(negedge CLK);
      total++;
      if ({Tx_DV_out, Tx_Byte_out, op_a, op_b, op_sub, op_start, err_pulse, drop_cnt} !== '0) begin
         bad++; $display("FAIL reset_outputs got=%h want=0",
            {Tx_DV_out, Tx_Byte_out, op_a, op_b, op_sub, op_start, err_pulse, drop_cnt});
      end
      RST = 1;
      repeat (3) @(negedge CLK);
      total++;
      if ({Tx_DV_out, op_start, err_pulse} !== 3'b000) begin
         bad++; $display("FAIL post_reset_idle got=%b want=000", {Tx_DV_out, op_start, err_pulse});
      end
   endtask

   task automatic test_add();
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'hA0, 8'h11, 8'hB4};
      start_frame();
      send5(8'h01, 8'h12, 8'h34, 8'hFF, 8'h80);
      wait_tx(3);
      total++;
      if (n_start != 1) begin bad++; $display("FAIL add_start_count got=%0d want=1", n_start); end
      total++;
      if ({cap_a, cap_b, cap_sub} !== {16'h1234, 16'hFF80, 1'b0}) begin
         bad++; $display("FAIL add_operands got=%h %h %b want=1234 ff80 0", cap_a, cap_b, cap_sub);
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp[i]) begin bad++; $display("FAIL add_tx[%0d] got=%h want=%h", i, got, exp[i]); end
      end
   endtask

   task automatic test_sub_ovf();
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'hA1, 8'h7F, 8'hFF};
      start_frame();
      send5(8'h02, 8'h80, 8'h00, 8'h00, 8'h01);
      wait_tx(3);
      total++;
      if (cap_sub !== 1'b1 || n_start != 1) begin
         bad++; $display("FAIL sub_start got=sub%b n%0d want=sub1 n1", cap_sub, n_start);
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp[i]) begin bad++; $display("FAIL sub_tx[%0d] got=%h want=%h", i, got, exp[i]); end
      end
   endtask

   task automatic test_bad_opcode();
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'hA2, 8'h00, 8'h00};
      start_frame();
      send5(8'h07, 8'h11, 8'h22, 8'h33, 8'h44);
      wait_tx(3);
      total++;
      if (n_start != 0) begin bad++; $display("FAIL bad_no_start got=%0d want=0", n_start); end
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp[i]) begin bad++; $display("FAIL bad_tx[%0d] got=%h want=%h", i, got, exp[i]); end
      end
   endtask

   task automatic test_timeout();
      int first_err;
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'hA0, 8'h00, 8'h03};
      start_frame();
      first_err = -1;
      send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
      for (int c = 1; c <= T + 20; c++) begin
         @(negedge CLK);
         if (err_pulse && first_err < 0) first_err = c;
      end
      total++;
      if (n_err != 1) begin bad++; $display("FAIL timeout_err_count got=%0d want=1", n_err); end
      total++;
      if (first_err < T - 2 || first_err > T + 2) begin
         bad++; $display("FAIL timeout_err_cycle got=%0d want=%0d+-2", first_err, T);
      end
      total++;
      if (n_start != 0 || tx_q.size() != 0) begin
         bad++; $display("FAIL timeout_discard got=start%0d tx%0d want=0 0", n_start, tx_q.size());
      end
      start_frame();
      send5(8'h01, 8'h00, 8'h01, 8'h00, 8'h02);
      wait_tx(3);
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp[i]) begin bad++; $display("FAIL after_timeout_tx[%0d] got=%h want=%h", i, got, exp[i]); end
      end
   endtask

   // the B_hi byte lands exactly on the expiry cycle and must be accepted
   task automatic test_byte_wins();
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'hA0, 8'h00, 8'h0C};
      start_frame();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
      repeat (T - 2) @(posedge CLK);
      send_byte(8'h00); send_byte(8'h07);
      wait_tx(3);
      total++;
      if (n_err != 0) begin bad++; $display("FAIL byte_wins_err got=%0d want=0", n_err); end
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp[i]) begin bad++; $display("FAIL byte_wins_tx[%0d] got=%h want=%h", i, got, exp[i]); end
      end
   endtask

   task automatic test_drop();
      logic [7:0] exp [3];
      logic [7:0] got;
      int k;
      exp = '{8'hA0, 8'h11, 8'hB4};
      start_frame();
      tx_delay = 25;
      send5(8'h01, 8'h12, 8'h34, 8'hFF, 8'h80);
      k = 0;
      while (tx_q.size() < 1 && k < 100) begin @(negedge CLK); k++; end
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
      wait_tx(3);
      total++;
      if (drop_cnt !== 8'd3) begin bad++; $display("FAIL drop_cnt got=%0d want=3", drop_cnt); end
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp[i]) begin bad++; $display("FAIL drop_tx[%0d] got=%h want=%h", i, got, exp[i]); end
      end
      tx_delay = 1;
   endtask

   task automatic test_dp_timeout();
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'hA4, 8'h00, 8'h00};
      start_frame();
      dp_en = 0;
      send5(8'h01, 8'h00, 8'h01, 8'h00, 8'h01);
      wait_tx(3);
      dp_en = 1;
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp[i]) begin bad++; $display("FAIL dpto_tx[%0d] got=%h want=%h", i, got, exp[i]); end
      end
   endtask

   task automatic test_reset_mid_tx();
      logic [7:0] exp [3];
      logic [7:0] got;
      int k;
      exp = '{8'hA0, 8'h00, 8'h02};
      start_frame();
      tx_delay = 10;
      send5(8'h01, 8'h12, 8'h34, 8'hFF, 8'h80);
      k = 0;
      while (tx_q.size() < 2 && k < 200) begin @(negedge CLK); k++; end
      repeat (3) @(negedge CLK);
      #2 RST = 0;
      #1;
      total++;
      if ({Tx_DV_out, Tx_Byte_out, op_a, op_b, op_sub, op_start, err_pulse, drop_cnt} !== '0) begin
         bad++; $display("FAIL midtx_reset_outputs got=%h want=0",
            {Tx_DV_out, Tx_Byte_out, op_a, op_b, op_sub, op_start, err_pulse, drop_cnt});
      end
      repeat (3) @(negedge CLK);
      RST = 1;
      repeat (30) @(negedge CLK);
      total++;
      if (tx_q.size() != 2) begin bad++; $display("FAIL midtx_no_more_tx got=%0d want=2", tx_q.size()); end
      tx_delay = 1;
      start_frame();
      send5(8'h01, 8'h00, 8'h01, 8'h00, 8'h01);
      wait_tx(3);
      for (int i = 0; i < 3; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp[i]) begin bad++; $display("FAIL post_reset_tx[%0d] got=%h want=%h", i, got, exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_ovf();
      test_bad_opcode();
      test_timeout();
      test_byte_wins();
      test_drop();
      test_dp_timeout();
      test_reset_mid_tx();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adder_cmd_ctrl.md
ADDER_CMD_CTRL -- requirements
Module: adder_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000: max idle cycles between RX bytes inside a frame.
REQ-002 SHALL have parameter DP_WAIT_MAX, default 16: max cycles from op_start to res_valid.
REQ-003 SHALL have port CLK, input, 1: single clock; all logic on posedge CLK.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port Rx_Byte_in, input, 8: received UART byte.
REQ-006 SHALL have port Rx_DV_in, input, 1: one-cycle strobe, Rx_Byte_in valid.
REQ-007 SHALL have port Tx_Done_in, input, 1: one-cycle strobe, UART TX finished current byte.
REQ-008 SHALL have port Tx_DV_out, output, 1: one-cycle strobe, Tx_Byte_out valid, start TX.
REQ-009 SHALL have port Tx_Byte_out, output, 8: byte to transmit.
REQ-010 SHALL have port op_a, output, 16: operand A to adder datapath.
REQ-011 SHALL have port op_b, output, 16: operand B to adder datapath.
REQ-012 SHALL have port op_sub, output, 1: 1 = A-B, 0 = A+B.
REQ-013 SHALL have port op_start, output, 1: one-cycle start pulse to datapath.
REQ-014 SHALL have port res, input, 16: datapath result.
REQ-015 SHALL have port res_ovf, input, 1: datapath signed overflow flag.
REQ-016 SHALL have port res_valid, input, 1: one-cycle strobe, res/res_ovf valid.
REQ-017 SHALL have port err_pulse, output, 1: one-cycle strobe on frame timeout.
REQ-018 SHALL have port drop_cnt, output, 8: count of RX bytes dropped while busy, saturating at 0xFF.

Function
REQ-019 SHALL accept a 5-byte frame: opcode, A_hi, A_lo, B_hi, B_lo.
REQ-020 SHALL decode opcode 0x01 as add and 0x02 as subtract; any other opcode is bad.
REQ-021 SHALL implement states IDLE -> RX_OPD -> EXEC -> WAIT -> TX_LOAD -> TX_WAIT -> IDLE.
REQ-022 IDLE SHALL latch the opcode on Rx_DV_in and go to RX_OPD with byte index 0.
REQ-023 RX_OPD SHALL store bytes 0..3 into op_a[15:8], op_a[7:0], op_b[15:8], op_b[7:0]; after index 3, go to EXEC, or go directly to TX_LOAD if the opcode is bad.
REQ-024 EXEC SHALL assert op_start for exactly one cycle with op_a, op_b and op_sub stable, then go to WAIT.
REQ-025 op_a, op_b and op_sub SHALL hold until the next frame's operand bytes overwrite them.
REQ-026 WAIT SHALL capture res and res_ovf on res_valid; after DP_WAIT_MAX cycles without res_valid, SHALL set the dp-timeout flag, set the result to 0x0000, and go to TX_LOAD.
REQ-027 Response SHALL be 3 bytes, in order: status, res[15:8], res[7:0].
REQ-028 Status byte SHALL be {4'hA, 1'b0, dp_timeout, bad_opcode, res_ovf}; bad opcode forces result 0x0000 and ovf 0.
REQ-029 TX_LOAD SHALL drive Tx_Byte_out and pulse Tx_DV_out for one cycle, then go to TX_WAIT.
REQ-030 TX_WAIT SHALL hold Tx_Byte_out until Tx_Done_in, then go to TX_LOAD for the next byte, or to IDLE after the third byte.
REQ-031 Tx_Done_in outside TX_WAIT SHALL be ignored.
REQ-032 Gap timer SHALL run in RX_OPD only, reset on every accepted byte; on reaching TIMEOUT_CYC, SHALL discard the frame, pulse err_pulse, and go to IDLE.
REQ-033 If Rx_DV_in coincides with timer expiry, the byte SHALL win: it is accepted, the timer is cleared, and there is no error.
REQ-034 Rx_DV_in in EXEC, WAIT, TX_LOAD or TX_WAIT SHALL drop the byte and increment drop_cnt, saturating at 0xFF.
REQ-035 Latency SHALL be: last RX strobe -> op_start in 2 cycles; res_valid -> first Tx_DV_out in 2 cycles.

Reset
REQ-036 RST low SHALL asynchronously force state IDLE and clear all of: Tx_DV_out, Tx_Byte_out, op_a, op_b, op_sub, op_start, err_pulse, drop_cnt, the flags, the timers and the byte index; this applies mid-frame or mid-TX.
REQ-037 After reset, the first Rx_DV_in SHALL be treated as an opcode.

Structure
REQ-038 Package adder_ctrl_pkg SHALL hold: the state enum, opcodes ADD=0x01 and SUB=0x02, status bit positions, and the status header nibble 0xA.
REQ-039 The gap timer SHALL be a sub-module byte_gap_timer (inputs: enable, clear; output: expired).

Verification (bench uses a 2-cycle-latency adder model)
REQ-040 Frame 01 12 34 FF 80 -> op_a 0x1234, op_b 0xFF80, op_sub 0, one op_start; TX bytes A0 11 B4.
REQ-041 Frame 02 80 00 00 01 -> model ovf 1; TX bytes A1 7F FF.
REQ-042 Frame 07 11 22 33 44 -> no op_start; TX bytes A2 00 00.
REQ-043 Frame 01 12 34, then TIMEOUT_CYC idle cycles -> one err_pulse, state IDLE; the next frame completes normally.
REQ-044 3 bytes sent during TX_WAIT -> drop_cnt 3; Tx_Done_in delayed 25 cycles still yields all 3 bytes in order.
REQ-045 RST low after 2 TX bytes -> all outputs zero immediately; no further Tx_DV_out.
